// File: rtl/seg_pkg.sv
// Shared constants for the 3-digit seven-segment scan driver: segment
// patterns {a,b,c,d,e,f,g} (active-high), digit-select encodings and digit lookup.
package seg_pkg;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;

    localparam logic [1:0] SEL_D0 = 2'b00;
    localparam logic [1:0] SEL_D1 = 2'b01;
    localparam logic [1:0] SEL_D2 = 2'b10;

    // d0 occupies the top nibble and is the leftmost digit.
    function automatic logic [3:0] digit_of(input logic [11:0] val, input logic [1:0] sel);
        case (sel)
            SEL_D0:  return val[11:8];
            SEL_D1:  return val[7:4];
            default: return val[3:0];
        endcase
    endfunction

endpackage

// File: rtl/seg_bcd_decode.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash.
module seg_bcd_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 3-digit seven-segment scan driver with frame-synchronous commit.
// Optional `LEADING_ZERO_BLANK_EN blanks leading zero digits of the committed value.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIV       = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [11:0] data,
    output logic [1:0]  sel,
    output logic [6:0]  seg,
    output logic        pend,
    output logic        frame
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK   = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic [11:0]      disp_q, disp_d;
    logic [11:0]      shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             frame_q, frame_d;

    logic             slot_end;
    logic             frame_end;
    logic             lz_blank;
    logic [3:0]       cur_digit;
    logic [6:0]       dec_seg;

    assign slot_end  = (cnt_q == CNT_MAX);
    assign frame_end = slot_end && (sel_q == SEL_D2);

    always_comb begin
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        sel_d    = sel_q;
        disp_d   = disp_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        frame_d  = 1'b0;

        if (slot_end) begin
            sel_d = (sel_q == SEL_D2) ? SEL_D0 : sel_q + 2'd1;
        end

        // A load landing on the frame-end cycle bypasses the shadow entirely.
        if (frame_end && load) begin
            disp_d  = data;
            pend_d  = 1'b0;
            frame_d = 1'b1;
        end else if (frame_end && pend_q) begin
            disp_d  = shadow_q;
            pend_d  = 1'b0;
            frame_d = 1'b1;
        end else if (load) begin
            shadow_d = data;
            pend_d   = 1'b1;
        end
    end

    // SEG is computed from next-state so it lines up with SEL on the same edge.
    assign cur_digit = digit_of(disp_d, sel_d);

    seg_bcd_decode u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign lz_blank = ((sel_d == SEL_D0) && (disp_d[11:8] == 4'd0)) ||
                      ((sel_d == SEL_D1) && (disp_d[11:4] == 8'd0));
`else
    assign lz_blank = 1'b0;
`endif

    assign seg_d = ((cnt_d < BLANK) || lz_blank) ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sel_q    <= SEL_D0;
            seg_q    <= SEG_BLANK;
            disp_q   <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            seg_q    <= seg_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            frame_q  <= frame_d;
        end
    end

    assign sel   = sel_q;
    assign seg   = seg_q;
    assign pend  = pend_q;
    assign frame = frame_q;

endmodule
